// File: rtl/sw_pkg.sv
// Shared types and constants for the switch output-port stage.
package sw_pkg;

  // Flit type carried alongside each data word.
  typedef enum logic [1:0] {
    NONE = 2'b00,
    HEAD = 2'b01,
    BODY = 2'b10,
    TAIL = 2'b11
  } flit_t;

  // Output-port arbiter states.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    XFER = 2'b10
  } arb_state_t;

  localparam logic ASSERT = 1'b1;
  localparam logic NEGATE = 1'b0;

  // Width of an index into n inputs; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sw_rr_pick.sv
// Round-robin picker: first set request at or above the pointer, with wrap.
module sw_rr_pick
  import sw_pkg::*;
#(
  parameter int NIN = 4,
  parameter int IW  = idx_w(NIN)
) (
  input  logic [NIN-1:0] req_i,
  input  logic [IW-1:0]  ptr_i,
  output logic [NIN-1:0] pick_o,
  output logic [IW-1:0]  idx_o
);

  // Scan pointer, pointer+1, ... wrapping at NIN; keep the first hit.
  always_comb begin
    logic          found;
    int            j;
    logic [IW-1:0] j_idx;
    pick_o = '0;
    idx_o  = '0;
    found  = NEGATE;
    j      = 0;
    j_idx  = '0;
    for (int k = 0; k < NIN; k++) begin
      j = int'(ptr_i) + k;
      if (j >= NIN) j = j - NIN;
      j_idx = IW'(j);
      if (!found && req_i[j_idx]) begin
        found         = ASSERT;
        pick_o[j_idx] = ASSERT;
        idx_o         = j_idx;
      end
    end
  end

endmodule

// File: rtl/sw_oport_arb.sv
// Output-port arbiter: round-robin grant per packet, HEAD..TAIL forwarding.
//
// state | meaning
// IDLE  | no grant; pick next requester from the rr pointer
// WAIT  | input granted, waiting for its HEAD; BODY/TAIL discarded
// XFER  | forwarding granted input's flits until TAIL
module sw_oport_arb
  import sw_pkg::*;
#(
  parameter int NIN = 4,
  parameter int DW  = 32,
  parameter int CW  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NIN-1:0]    req,
  output logic [NIN-1:0]    ack,
  input  logic [NIN*DW-1:0] din,
  input  logic [NIN*2-1:0]  tin,
  output logic [DW-1:0]     dout,
  output logic [1:0]        tout,
  output logic              ovalid,
  output logic [CW-1:0]     pkt_cnt
);

  localparam int IW = idx_w(NIN);

  arb_state_t     state_q, state_d;
  logic [NIN-1:0] grant_q, grant_d;
  logic [IW-1:0]  gidx_q, gidx_d;
  logic [IW-1:0]  rr_q, rr_d;
  logic [DW-1:0]  dout_q, dout_d;
  flit_t          tout_q, tout_d;
  logic           ovalid_q, ovalid_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic [NIN-1:0] pick;
  logic [IW-1:0]  pick_idx;
  logic           g_req;
  flit_t          g_tin;
  logic [DW-1:0]  g_din;
  logic [IW-1:0]  rr_next;

  sw_rr_pick #(
    .NIN (NIN),
    .IW  (IW)
  ) u_pick (
    .req_i  (req),
    .ptr_i  (rr_q),
    .pick_o (pick),
    .idx_o  (pick_idx)
  );

  // gidx_q is only meaningful while a grant is held (WAIT/XFER).
  assign g_req   = req[gidx_q];
  assign g_tin   = flit_t'(tin[{gidx_q, 1'b0} +: 2]);
  assign g_din   = din[int'(gidx_q) * DW +: DW];
  assign rr_next = (gidx_q == IW'(NIN - 1)) ? '0 : gidx_q + 1'b1;

  // Next-state, grant, datapath and ack decode.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    gidx_d   = gidx_q;
    rr_d     = rr_q;
    dout_d   = dout_q;
    tout_d   = NONE;
    ovalid_d = NEGATE;
    cnt_d    = cnt_q;
    ack      = '0;

    unique case (state_q)
      IDLE: begin
        if (|req) begin
          grant_d = pick;
          gidx_d  = pick_idx;
          state_d = WAIT;
        end
      end

      WAIT: begin
        ack = grant_q & req;
        if (!g_req) begin
          grant_d = '0;
          rr_d    = rr_next;
          state_d = IDLE;
        end else if (g_tin == HEAD) begin
          dout_d   = g_din;
          tout_d   = HEAD;
          ovalid_d = ASSERT;
          state_d  = XFER;
        end
      end

      XFER: begin
        ack = grant_q;
        if (g_tin != NONE) begin
          dout_d   = g_din;
          tout_d   = g_tin;
          ovalid_d = ASSERT;
        end
        if (g_tin == TAIL) begin
          grant_d = '0;
          rr_d    = rr_next;
          cnt_d   = cnt_q + 1'b1;
          state_d = IDLE;
        end
      end

      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State, grant and registered output stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      gidx_q   <= '0;
      rr_q     <= '0;
      dout_q   <= '0;
      tout_q   <= NONE;
      ovalid_q <= NEGATE;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      gidx_q   <= gidx_d;
      rr_q     <= rr_d;
      dout_q   <= dout_d;
      tout_q   <= tout_d;
      ovalid_q <= ovalid_d;
      cnt_q    <= cnt_d;
    end
  end

  assign dout    = dout_q;
  assign tout    = tout_q;
  assign ovalid  = ovalid_q;
  assign pkt_cnt = cnt_q;

endmodule
